pong_ctrl: RTL and testbench

PONG_CTRL -- requirements
Module: pong_ctrl

---
 rtl/pong_ctrl.sv | 157 +++++++++++++++
 tb/tb_pong_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pong_ctrl.sv
// Pong game controller: sequences IDLE/SERVE/PLAY/SCORE/GAMEOVER, keeps score and
// the ball direction, and issues one-cell step vectors to the ball position block.
module pong_ctrl #(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int PADDLE_LEN   = 2,
  parameter int WIN_SCORE    = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        tick,
  input  logic [2*BIT_OF_WIDTH-1:0]   ball_pos,
  input  logic [BIT_OF_WIDTH-1:0]     paddle_l,
  input  logic [BIT_OF_WIDTH-1:0]     paddle_r,
  output logic                        ball_en,
  output logic [3:0]                  ball_vector,
  output logic [3:0]                  score_l,
  output logic [3:0]                  score_r,
  output logic                        game_over
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_SCORE    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam int BW1 = BIT_OF_WIDTH + 1;
  localparam logic [1:0] V_POS = 2'b01;
  localparam logic [1:0] V_NEG = 2'b11;
  localparam logic [3:0] DIR_RESET = 4'b0101;
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [BIT_OF_WIDTH-1:0] X_ZERO = BIT_OF_WIDTH'(0);
  localparam logic [BIT_OF_WIDTH-1:0] X_ONE  = BIT_OF_WIDTH'(1);
  localparam logic [BIT_OF_WIDTH-1:0] X_MAX  = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [BIT_OF_WIDTH-1:0] X_NEAR = BIT_OF_WIDTH'(WIDTH - 2);
  localparam logic [BW1-1:0] PAD_SPAN = BW1'(PADDLE_LEN - 1);

  state_t state_q, state_d;
  logic [3:0] dir_q, dir_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic [BIT_OF_WIDTH-1:0] ball_x_s, ball_y_s;
  logic [1:0] dx_n_s, dy_n_s;

  // Paddle span is compared one bit wider so a paddle at the bottom edge never wraps.
  function automatic logic covered(input logic [BIT_OF_WIDTH-1:0] top,
                                   input logic [BIT_OF_WIDTH-1:0] y);
    logic [BW1-1:0] bottom;
    bottom = {1'b0, top} + PAD_SPAN;
    return (y >= top) && ({1'b0, y} <= bottom);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s < WIN) ? s + 4'd1 : s;
  endfunction

  assign ball_x_s = ball_pos[2*BIT_OF_WIDTH-1:BIT_OF_WIDTH];
  assign ball_y_s = ball_pos[BIT_OF_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_RESET;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  // Wall and paddle reflections are resolved independently so corners flip both axes.
  always_comb begin
    dx_n_s = dir_q[3:2];
    dy_n_s = dir_q[1:0];
    if (ball_y_s == X_ZERO && dir_q[1:0] == V_NEG) begin
      dy_n_s = V_POS;
    end else if (ball_y_s == X_MAX && dir_q[1:0] == V_POS) begin
      dy_n_s = V_NEG;
    end else begin
      dy_n_s = dir_q[1:0];
    end
    if (ball_x_s == X_ONE && dir_q[3:2] == V_NEG && covered(paddle_l, ball_y_s)) begin
      dx_n_s = V_POS;
    end else if (ball_x_s == X_NEAR && dir_q[3:2] == V_POS && covered(paddle_r, ball_y_s)) begin
      dx_n_s = V_NEG;
    end else begin
      dx_n_s = dir_q[3:2];
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    ball_vector = 4'b0000;
    ball_en     = 1'b0;
    game_over   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SERVE;
        else       state_d = S_IDLE;
      end
      S_SERVE: begin
        if (tick) state_d = S_PLAY;
        else      state_d = S_SERVE;
      end
      S_PLAY: begin
        ball_en = 1'b1;
        if (tick) begin
          // A goal is checked before any reflection and issues no move.
          if (ball_x_s == X_ZERO) begin
            score_r_d = sat_inc(score_r_q);
            dir_d     = {V_NEG, dir_q[1:0]};
            state_d   = S_SCORE;
          end else if (ball_x_s == X_MAX) begin
            score_l_d = sat_inc(score_l_q);
            dir_d     = {V_POS, dir_q[1:0]};
            state_d   = S_SCORE;
          end else begin
            dir_d       = {dx_n_s, dy_n_s};
            ball_vector = {dx_n_s, dy_n_s};
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_SCORE: begin
        if (score_l_q == WIN || score_r_q == WIN) state_d = S_GAMEOVER;
        else                                      state_d = S_SERVE;
      end
      S_GAMEOVER: begin
        game_over = 1'b1;
        if (start) begin
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          dir_d     = DIR_RESET;
          state_d   = S_SERVE;
        end else begin
          state_d = S_GAMEOVER;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule

// File: tb/tb_pong_ctrl.sv
// Directed bench for pong_ctrl: stimulus pushes hand-computed expectations into a
// queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_pong_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       tick;
  logic [5:0] ball_pos;
  logic [2:0] paddle_l;
  logic [2:0] paddle_r;
  logic       ball_en;
  logic [3:0] ball_vector;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;

  typedef struct {
    string      name;
    logic [3:0] vec;
    logic       en;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  pong_ctrl #(.WIDTH(8), .BIT_OF_WIDTH(3), .PADDLE_LEN(2), .WIN_SCORE(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tick       (tick),
    .ball_pos   (ball_pos),
    .paddle_l   (paddle_l),
    .paddle_r   (paddle_r),
    .ball_en    (ball_en),
    .ball_vector(ball_vector),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the outputs are stable at the falling edge, between input updates.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total = total + 1;
      if (ball_vector !== e.vec || ball_en !== e.en || score_l !== e.sl ||
          score_r !== e.sr || game_over !== e.go) begin
        bad = bad + 1;
        $display("FAIL %s: got vec=%b en=%b sl=%0d sr=%0d go=%b, want vec=%b en=%b sl=%0d sr=%0d go=%b",
                 e.name, ball_vector, ball_en, score_l, score_r, game_over,
                 e.vec, e.en, e.sl, e.sr, e.go);
      end
    end
  end

  task automatic step(input logic st, input logic tk, input int x, input int y,
                      input int pl, input int pr);
    logic [2:0] xs, ys;
    @(posedge clk);
    #1;
    xs = 3'(x);
    ys = 3'(y);
    start    = st;
    tick     = tk;
    ball_pos = {xs, ys};
    paddle_l = 3'(pl);
    paddle_r = 3'(pr);
  endtask

  task automatic ex(input string name, input logic [3:0] vec, input logic en,
                    input int sl, input int sr, input logic go);
    exp_t e;
    e.name = name;
    e.vec  = vec;
    e.en   = en;
    e.sl   = 4'(sl);
    e.sr   = 4'(sr);
    e.go   = go;
    exp_q.push_back(e);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    tick     = 1'b0;
    ball_pos = 6'b100100;
    paddle_l = 3'd0;
    paddle_r = 3'd0;

    step(1'b0, 1'b0, 4, 4, 0, 0);  ex("reset",             4'b0000, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 4, 4, 0, 0);  rst = 1'b0;
                                   ex("idle_start_tick",   4'b0000, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("serve_tick",        4'b0000, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 4, 4, 0, 0);  ex("play_no_tick",      4'b0000, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("play_centre",       4'b0101, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 3, 7, 0, 0);  ex("bottom_wall",       4'b0111, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b0, 3, 6, 0, 0);  ex("between_ticks",     4'b0000, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 3, 6, 0, 0);  ex("dir_held",          4'b0111, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 6, 5, 0, 5);  ex("paddle_r_hit",      4'b1111, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1, 3, 2, 0);  ex("paddle_l_hit",      4'b0111, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 6, 3, 0, 2);  ex("paddle_r_hit2",     4'b1111, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1, 3, 5, 0);  ex("paddle_l_miss",     4'b1111, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 2, 0, 0);  ex("left_goal",         4'b0000, 1'b1, 0, 0, 1'b0);
    step(1'b1, 1'b0, 4, 4, 0, 0);  ex("score_state",       4'b0000, 1'b0, 0, 1, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("reserve",           4'b0000, 1'b0, 0, 1, 1'b0);
    step(1'b0, 1'b1, 0, 0, 0, 0);  ex("corner_goal",       4'b0000, 1'b1, 0, 1, 1'b0);
    step(1'b0, 1'b0, 4, 4, 0, 0);  ex("score_state2",      4'b0000, 1'b0, 0, 2, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("reserve2",          4'b0000, 1'b0, 0, 2, 1'b0);
    step(1'b0, 1'b1, 1, 0, 0, 0);  ex("corner_reflect",    4'b0101, 1'b1, 0, 2, 1'b0);
    step(1'b0, 1'b1, 3, 7, 0, 0);  ex("bottom_wall2",      4'b0111, 1'b1, 0, 2, 1'b0);

    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 7, 4, 0, 0);  ex("right_goal",      4'b0000, 1'b1, i, 2, 1'b0);
      step(1'b0, 1'b0, 4, 4, 0, 0);  ex("score_l_inc",     4'b0000, 1'b0, i + 1, 2, 1'b0);
      if (i < 6) begin
        step(1'b0, 1'b1, 4, 4, 0, 0);  ex("serve_again",   4'b0000, 1'b0, i + 1, 2, 1'b0);
      end
    end

    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("gameover_tick",     4'b0000, 1'b0, 7, 2, 1'b1);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("gameover_hold",     4'b0000, 1'b0, 7, 2, 1'b1);
    step(1'b1, 1'b1, 4, 4, 0, 0);  ex("gameover_start",    4'b0000, 1'b0, 7, 2, 1'b1);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("cleared_serve",     4'b0000, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("dir_reset",         4'b0101, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 4, 0, 0);  ex("goal_again",        4'b0000, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b0, 4, 4, 0, 0);  ex("score_state3",      4'b0000, 1'b0, 0, 1, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("reserve3",          4'b0000, 1'b0, 0, 1, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("play_before_rst",   4'b1101, 1'b1, 0, 1, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  rst = 1'b1;
                                   ex("async_reset",       4'b0000, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  rst = 1'b0;
                                   ex("idle_after_reset",  4'b0000, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 4, 4, 0, 0);  ex("idle_ignores_tick", 4'b0000, 1'b0, 0, 0, 1'b0);

    @(negedge clk);
    #1;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
